dmem_store_buffer: RTL and testbench

- Data-side memory stage placed directly downstream of the pipelined arm core's memory-stage outputs.
- Posts stores into a DEPTH-entry FIFO and forwards buffered store data to matching loads.
- Services load misses and buffer drains over a single req/ack port to the backing data RAM.
- Asserts StallM to freeze the pipeline while a load miss is outstanding or while a store arrives with the buffer full.

---
 rtl/dmem_store_buffer_if.sv | 43 ++++
 rtl/dmem_store_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if
// Request/acknowledge bus between the data-side store buffer and the backing
// data RAM. Only one transaction is outstanding at a time. The requester holds
// mem_req and its payload stable until the RAM returns mem_ack.
//
// Signals:
//   mem_req    requester -> RAM   transaction request
//   mem_we     requester -> RAM   1 = write, 0 = read
//   mem_addr   requester -> RAM   word-aligned byte address (bits [1:0] = 0)
//   mem_wdata  requester -> RAM   write data
//   mem_rdata  RAM -> requester   read data, valid while mem_ack is high on a read
//   mem_ack    RAM -> requester   transaction completes at this clock edge
//
// Modports: master = store buffer side, slave = RAM side.

interface dmem_store_buffer_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Data-side memory stage sitting right after the core's memory-stage outputs.
// Stores are posted into a DEPTH-entry FIFO and drained to the backing RAM in
// strict order. Loads that match a buffered store are answered from the youngest
// matching entry in the same cycle. Loads that miss are read from the RAM while
// the pipeline is frozen.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   MemWriteM   store request this cycle
//   MemReadM    load request this cycle (ignored when MemWriteM is also high)
//   ALUResultM  byte address, word index is ALUResultM[AW-1:2]
//   WriteDataM  store data
//   ReadDataM   load data to the core (hit data, or RAM data in the DONE cycle, else 0)
//   StallM      freeze the pipeline; the core holds its inputs while high
//   mem         backing-RAM req/ack bus (master side)
//   BufEmpty    no buffered stores
//   BufFull     buffer holds DEPTH stores

module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWriteM,
  input  logic                MemReadM,
  input  logic [AW-1:0]       ALUResultM,
  input  logic [31:0]         WriteDataM,
  output logic [31:0]         ReadDataM,
  output logic                StallM,
  dmem_store_buffer_if.master mem,
  output logic                BufEmpty,
  output logic                BufFull
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = AW - 2;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  state_t state;

  // Store entries: word address and data, plus a valid bit per slot.
  logic [WW-1:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  // Registered bus payload, held for the whole WR/RD transaction.
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic [WW-1:0] word_addr;
  logic          unused_byte_offset;

  logic          hit;
  logic [31:0]   hit_data;
  logic          load_req;
  logic          load_hit;
  logic          load_miss;
  logic          full;
  logic          enq;
  logic          pop;
  logic          issue_rd;

  // Matching and the RAM address are word granular, byte offset is dropped.
  assign word_addr          = ALUResultM[AW-1:2];
  assign unused_byte_offset = ^ALUResultM[1:0];

  // Search the buffer from oldest to youngest so the last match found is the
  // youngest store to this word.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_valid[idx] && (ent_addr[idx] == word_addr)) begin
        hit      = 1'b1;
        hit_data = ent_data[idx];
      end
    end
  end

  // A simultaneous store and load is treated as a store only.
  assign load_req  = MemReadM && !MemWriteM;
  assign load_hit  = load_req && hit;
  assign load_miss = load_req && !hit;

  assign full     = (count == (PW+1)'(DEPTH));
  assign enq      = MemWriteM && !full;
  assign pop      = (state == WR) && mem.mem_ack;

  // A load miss seen in IDLE raises the read request in the same cycle, which
  // is what lets a zero-wait ack finish the miss in two cycles.
  assign issue_rd = (state == IDLE) && load_miss;

  assign mem.mem_req   = req_q | issue_rd;
  assign mem.mem_we    = issue_rd ? 1'b0 : we_q;
  assign mem.mem_addr  = issue_rd ? {word_addr, 2'b00} : addr_q;
  assign mem.mem_wdata = wdata_q;

  // The DONE cycle releases the pipeline even though the load is still
  // presented, since its data is now ready.
  assign StallM    = (state != DONE) && (load_miss || (MemWriteM && full));
  assign ReadDataM = (state == DONE) ? rdata_q :
                     (load_hit ? hit_data : 32'h0);

  assign BufEmpty = (count == '0);
  assign BufFull  = full;

  // Entry payload storage; slots are only meaningful while valid, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= word_addr;
      ent_data[tail] <= WriteDataM;
    end
  end

  // Pointer, occupancy, FSM and registered bus payload. Reset abandons any
  // outstanding transaction and discards buffered stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      // A pop only happens with entries present and an enqueue only when not
      // full, so both can never target the same slot.
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, pop};

      case (state)
        IDLE: begin
          if (load_miss) begin
            if (mem.mem_ack) begin
              rdata_q <= mem.mem_rdata;
              state   <= DONE;
            end else begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= {word_addr, 2'b00};
              state  <= RD;
            end
          end else if (count != '0) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= {ent_addr[head], 2'b00};
            wdata_q <= ent_data[head];
            state   <= WR;
          end
        end
        WR: begin
          if (mem.mem_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            state <= IDLE;
          end
        end
        RD: begin
          if (mem.mem_ack) begin
            req_q   <= 1'b0;
            rdata_q <= mem.mem_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
// Drives dmem_store_buffer as both the core and the backing RAM. Expected
// outputs come from a reference model made of a FIFO queue of posted stores,
// an associative-array image of the RAM, and a note of which bus transaction
// is in flight. Directed scenarios are followed by a randomized run.

module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic        MemReadM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BufEmpty;
  logic        BufFull;

  dmem_store_buffer_if #(.AW(AW)) mem_bus ();

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem        (mem_bus),
    .BufEmpty   (BufEmpty),
    .BufFull    (BufFull)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
  } entry_t;

  entry_t      sbq[$];
  logic [31:0] ram [logic [29:0]];
  int          xact;          // 0 = no bus transaction, 1 = drain write, 2 = miss read
  bit          done_cycle;
  logic [31:0] load_result;
  bit          exp_stall_q;

  logic [31:0] last_read;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  bit          last_stall, last_req, last_we, last_full, last_empty;
  logic [31:0] wr_log[$];

  function automatic logic [31:0] ram_read(input logic [29:0] w);
    return ram.exists(w) ? ram[w] : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive core and RAM inputs, check every output against the
  // model at the falling edge, then advance the model across the rising edge.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [31:0] data, input bit ack);
    logic [29:0] word;
    bit          ld, hit, miss, full, exp_stall, exp_req, exp_we;
    logic [31:0] hit_data, exp_read, exp_addr;
    word = addr[31:2];
    if (wr && rd) $display("[TB] protocol error: store and load requested together");
    MemWriteM         = wr;
    MemReadM          = rd;
    ALUResultM        = addr;
    WriteDataM        = data;
    mem_bus.mem_ack   = ack;
    mem_bus.mem_rdata = rd ? ram_read(word) : $urandom();
    @(negedge clk);

    ld       = rd && !wr;
    hit      = 1'b0;
    hit_data = '0;
    foreach (sbq[i]) begin
      if (sbq[i].word == word) begin
        hit      = 1'b1;
        hit_data = sbq[i].data;
      end
    end
    miss = ld && !hit;
    full = (sbq.size() == DEPTH);
    if (done_cycle) begin
      exp_stall = 1'b0;
      exp_read  = load_result;
      exp_req   = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
    end else begin
      exp_stall = miss || (wr && full);
      exp_read  = (ld && hit) ? hit_data : 32'h0;
      exp_req   = (xact != 0) || miss;
      exp_we    = (xact == 1);
      exp_addr  = (xact == 1) ? {sbq[0].word, 2'b00} : {word, 2'b00};
    end

    checkOutput("StallM", StallM, exp_stall);
    checkOutput("ReadDataM", ReadDataM, exp_read);
    checkOutput("mem_req", mem_bus.mem_req, exp_req);
    if (exp_req) begin
      checkOutput("mem_we", mem_bus.mem_we, exp_we);
      checkOutput("mem_addr", mem_bus.mem_addr, exp_addr);
      if (exp_we) checkOutput("mem_wdata", mem_bus.mem_wdata, sbq[0].data);
    end
    checkOutput("BufEmpty", BufEmpty, sbq.size() == 0);
    checkOutput("BufFull", BufFull, full);

    last_read  = ReadDataM;
    last_stall = StallM;
    last_req   = mem_bus.mem_req;
    last_we    = mem_bus.mem_we;
    last_addr  = mem_bus.mem_addr;
    last_wdata = mem_bus.mem_wdata;
    last_full  = BufFull;
    last_empty = BufEmpty;
    if (mem_bus.mem_req && mem_bus.mem_we && ack) wr_log.push_back(mem_bus.mem_addr);

    if (done_cycle) begin
      done_cycle = 1'b0;
    end else if (xact == 1) begin
      if (ack) begin
        ram[sbq[0].word] = sbq[0].data;
        sbq.delete(0);
        xact = 0;
      end
    end else if (xact == 2) begin
      if (ack) begin
        load_result = ram_read(word);
        done_cycle  = 1'b1;
        xact        = 0;
      end
    end else if (miss) begin
      if (ack) begin
        load_result = ram_read(word);
        done_cycle  = 1'b1;
      end else begin
        xact = 2;
      end
    end else if (sbq.size() != 0) begin
      xact = 1;
    end
    if (wr && !full) sbq.push_back('{word, data});
    exp_stall_q = exp_stall;

    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset           = 1'b1;
    MemWriteM       = 1'b0;
    MemReadM        = 1'b0;
    mem_bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    mem_bus.mem_ack = 1'b0;
    sbq.delete();
    xact        = 0;
    done_cycle  = 1'b0;
    exp_stall_q = 1'b0;
  endtask

  initial begin
    int          stall_cnt;
    bit          seen;
    bit          op_wr, op_rd;
    logic [31:0] op_addr, op_data;

    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    xact              = 0;
    done_cycle        = 1'b0;
    exp_stall_q       = 1'b0;
    load_result       = '0;
    @(posedge clk);
    #1;
    doReset();

    // Reset state
    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    checkOutput("rst_empty", last_empty, 1);
    checkOutput("rst_full", last_full, 0);
    checkOutput("rst_stall", last_stall, 0);
    checkOutput("rst_req", last_req, 0);
    checkOutput("rst_we", last_we, 0);
    checkOutput("rst_addr", last_addr, 32'h0);
    checkOutput("rst_wdata", last_wdata, 32'h0);
    checkOutput("rst_read", last_read, 32'h0);

    // Store forwarding to a load with a different byte offset, then drain
    applyStimulus(1, 0, 32'h40, 32'hDEADBEEF, 0);
    applyStimulus(0, 1, 32'h43, 32'h0, 0);
    checkOutput("fwd_data", last_read, 32'hDEADBEEF);
    checkOutput("fwd_stall", last_stall, 0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 32'h0, 32'h0, 1);
      if (last_req && last_we && last_addr == 32'h40) seen = 1'b1;
    end
    checkOutput("drain_0x40_seen", seen, 1);

    // Youngest match wins
    applyStimulus(1, 0, 32'h80, 32'h11, 0);
    applyStimulus(1, 0, 32'h80, 32'h22, 0);
    applyStimulus(0, 1, 32'h80, 32'h0, 0);
    checkOutput("youngest_data", last_read, 32'h22);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 32'h0, 32'h0, 1);

    // Fill the buffer, stall the fifth store until the first pop
    wr_log.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k), 0);
    applyStimulus(1, 0, 32'h210, 32'hA4, 0);
    checkOutput("full_flag", last_full, 1);
    checkOutput("full_stall", last_stall, 1);
    applyStimulus(1, 0, 32'h210, 32'hA4, 0);
    applyStimulus(1, 0, 32'h210, 32'hA4, 1);
    checkOutput("full_stall_ack", last_stall, 1);
    applyStimulus(1, 0, 32'h210, 32'hA4, 0);
    checkOutput("full_accept", last_stall, 0);
    for (int k = 0; k < 14; k++) applyStimulus(0, 0, 32'h0, 32'h0, 1);
    checkOutput("drain_count", wr_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < wr_log.size()) checkOutput("drain_order", wr_log[k], 32'h200 + 32'(4 * k));
    end

    // Load miss with ack three cycles late
    ram[30'h40] = 32'h12345678;
    stall_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 32'h100, 32'h0, k == 3);
      if (last_stall) stall_cnt++;
    end
    checkOutput("miss_stall_cycles", stall_cnt, 4);
    checkOutput("miss_data", last_read, 32'h12345678);
    checkOutput("miss_done_stall", last_stall, 0);

    // Load miss behind a pending drain write, then a zero-wait read
    ram[30'h41] = 32'hCAFEF00D;
    applyStimulus(1, 0, 32'h300, 32'h55, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    stall_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 32'h104, 32'h0, k >= 2);
      if (last_stall) stall_cnt++;
    end
    checkOutput("wr_then_rd_stall", stall_cnt, 4);
    checkOutput("wr_then_rd_data", last_read, 32'hCAFEF00D);

    // Reset while a read is outstanding with two stores still buffered
    applyStimulus(1, 0, 32'h400, 32'h1, 0);
    applyStimulus(1, 0, 32'h404, 32'h2, 0);
    applyStimulus(1, 0, 32'h408, 32'h3, 0);
    applyStimulus(0, 1, 32'h500, 32'h0, 0);
    applyStimulus(0, 1, 32'h500, 32'h0, 1);
    applyStimulus(0, 1, 32'h500, 32'h0, 0);
    checkOutput("pre_rst_read_req", last_req && !last_we, 1);
    doReset();
    applyStimulus(0, 0, 32'h0, 32'h0, 1);
    checkOutput("post_rst_req", last_req, 0);
    checkOutput("post_rst_empty", last_empty, 1);
    checkOutput("post_rst_stall", last_stall, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1);
    checkOutput("stray_ack_empty", last_empty, 1);
    checkOutput("stray_ack_req", last_req, 0);

    // Randomized traffic over a small address window
    op_wr   = 1'b0;
    op_rd   = 1'b0;
    op_addr = '0;
    op_data = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
        op_wr = 1'b0;
        op_rd = 1'b0;
      end else begin
        if (!exp_stall_q) begin
          int r;
          r       = $urandom_range(0, 99);
          op_wr   = (r < 40);
          op_rd   = (r >= 40) && (r < 75);
          op_addr = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
          op_data = $urandom();
        end
        applyStimulus(op_wr, op_rd, op_addr, op_data, $urandom_range(0, 99) < 50);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
